// File: rtl/ysyx_22051013_ifu_fetch_pkg.sv
// Shared constants and types for the ysyx_22051013 fetch stage.
// YSYX_22051013_IFU_MISALIGN_EN selects halting on misaligned redirects instead of forcing alignment.
package ysyx_22051013_ifu_fetch_pkg;

  localparam logic [63:0] PC_RESET = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef logic [31:0] inst_t;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;

`ifdef YSYX_22051013_IFU_MISALIGN_EN
  localparam bit MISALIGN_EN = 1'b1;
`else
  localparam bit MISALIGN_EN = 1'b0;
`endif

endpackage

// File: rtl/ysyx_22051013_ifu_fetch_if.sv
// Instruction-memory request/response channel plus the fetch-to-decode handshake.
interface ysyx_22051013_ifu_fetch_if;
  import ysyx_22051013_ifu_fetch_pkg::*;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  inst_t       imem_rsp_data;
  logic        id_valid;
  logic        id_ready;
  logic [63:0] id_pc;
  inst_t       id_inst;

  modport master (
    output imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, id_pc, id_inst,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, id_ready
  );

endinterface

// File: rtl/ysyx_22051013_ifu_fetch_pc.sv
// PC register and next-PC mux (hold / +4 / redirect) for the fetch stage.
// Without YSYX_22051013_IFU_MISALIGN_EN the redirect target is forced word-aligned.
module ysyx_22051013_ifu_pc
  import ysyx_22051013_ifu_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = PC_RESET
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_inc,
  input  logic        pc_load,
  input  logic [63:0] redirect_pc,
  output logic [63:0] pc
);

  logic [63:0] target;
  logic [63:0] pc_next;

  // Redirect beats increment; the top never asserts both for a useful reason.
  always_comb begin
    target  = MISALIGN_EN ? redirect_pc : {redirect_pc[63:2], 2'b00};
    pc_next = pc;
    if (pc_load) begin
      pc_next = target;
    end else if (pc_inc) begin
      pc_next = pc + 64'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/ysyx_22051013_ifu_fetch.sv
// Fetch stage: one outstanding imem read, buffered instruction handed to decode, redirect/kill.
// YSYX_22051013_IFU_MISALIGN_EN enables the sticky misalign_err flag and the S_HALT state.
module ysyx_22051013_ifu_fetch
  import ysyx_22051013_ifu_fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = PC_RESET,
  parameter logic [31:0] NOP_INST = NOP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect_valid,
  input  logic [63:0]                redirect_pc,
  ysyx_22051013_ifu_fetch_if.master  bus,
  output logic                       misalign_err
);

  fetch_state_e state;
  logic         kill;
  logic         err_q;
  inst_t        inst_q;
  logic [63:0]  pc_q;
  logic [63:0]  pc;

  logic req_fire;
  logic redirect_bad;
  logic halt_now;
  logic pc_load;
  logic pc_inc;

  assign req_fire     = bus.imem_req_valid && bus.imem_req_ready;
  assign redirect_bad = MISALIGN_EN && (redirect_pc[1:0] != 2'b00);
  assign halt_now     = redirect_valid && redirect_bad && (state != S_HALT);
  assign pc_load      = redirect_valid && !redirect_bad && (state != S_HALT);
  assign pc_inc       = (state == S_HOLD) && bus.id_ready && !redirect_valid;

  ysyx_22051013_ifu_pc #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst         (rst),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .redirect_pc (redirect_pc),
    .pc          (pc)
  );

  // Any redirect either kills the in-flight read or drops the held instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_REQ;
      kill   <= 1'b0;
      err_q  <= 1'b0;
      inst_q <= NOP_INST;
      pc_q   <= RESET_PC;
    end else if (halt_now) begin
      state  <= S_HALT;
      kill   <= 1'b0;
      err_q  <= 1'b1;
      inst_q <= NOP_INST;
    end else begin
      case (state)
        S_REQ: begin
          if (req_fire) begin
            state <= S_WAIT;
            kill  <= pc_load;
          end
        end
        S_WAIT: begin
          if (bus.imem_rsp_valid) begin
            if (kill || pc_load) begin
              state <= S_REQ;
              kill  <= 1'b0;
            end else begin
              inst_q <= bus.imem_rsp_data;
              pc_q   <= pc;
              state  <= S_HOLD;
            end
          end else if (pc_load) begin
            kill <= 1'b1;
          end
        end
        S_HOLD: begin
          if (pc_load || bus.id_ready) begin
            state  <= S_REQ;
            inst_q <= NOP_INST;
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
      endcase
    end
  end

  assign bus.imem_req_valid = (state == S_REQ) && !rst;
  assign bus.imem_req_addr  = pc;
  assign bus.id_valid       = (state == S_HOLD);
  assign bus.id_pc          = pc_q;
  assign bus.id_inst        = inst_q;
  assign misalign_err       = err_q;

endmodule
